// File: rtl/display_pkg.sv
// Shared digit indices, scan states and digit helpers for the
// seven-segment clock display blocks.
package display_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] dig_idx_t;

    localparam dig_idx_t DIG_SEG1  = 3'd0;
    localparam dig_idx_t DIG_SEG2  = 3'd1;
    localparam dig_idx_t DIG_MIN1  = 3'd2;
    localparam dig_idx_t DIG_MIN2  = 3'd3;
    localparam dig_idx_t DIG_HORA1 = 3'd4;
    localparam dig_idx_t DIG_HORA2 = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // snap packs {hora, min, seg}; nibbles are passed through unvalidated
    function automatic logic [3:0] pick_digit(
        input logic [23:0] snap,
        input dig_idx_t    idx
    );
        logic [3:0] nib;
        nib = 4'd0;
        case (idx)
            DIG_SEG1:  nib = snap[3:0];
            DIG_SEG2:  nib = snap[7:4];
            DIG_MIN1:  nib = snap[11:8];
            DIG_MIN2:  nib = snap[15:12];
            DIG_HORA1: nib = snap[19:16];
            DIG_HORA2: nib = snap[23:20];
            default:   nib = 4'd0;
        endcase
        return nib;
    endfunction

    function automatic dig_idx_t next_digit(input dig_idx_t idx);
        return (idx >= DIG_HORA2) ? DIG_SEG1 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/barrido_display_if.sv
// Time inputs, scan enable and digit outputs between the clock core,
// the scan controller and the anode / segment decoders.
interface barrido_display_if;
    import display_pkg::*;

    logic       enable;
    logic [7:0] seg_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hora_bcd;
    dig_idx_t   cont_anodo;
    logic [3:0] digito_bcd;
    logic       blank;
    logic       frame_start;

    modport master (
        output enable, seg_bcd, min_bcd, hora_bcd,
        input  cont_anodo, digito_bcd, blank, frame_start
    );

    modport slave (
        input  enable, seg_bcd, min_bcd, hora_bcd,
        output cont_anodo, digito_bcd, blank, frame_start
    );

endinterface

// File: rtl/barrido_display_contador_divisor.sv
// Terminal-count counter with synchronous clear; done is high on the
// last enabled cycle of each TERMINAL-cycle period.
module contador_divisor #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    logic [WIDTH-1:0] cnt;

    assign done = en && (cnt == WIDTH'(TERMINAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/barrido_display.sv
// Six-digit scan controller: per-frame snapshot of the time, digit
// stepping 0..5 with a show dwell and an anti-ghost blanking gap.
module barrido_display
    import display_pkg::*;
#(
    parameter int DIV_COUNT    = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic         clk,
    input  logic         reset,
    barrido_display_if.slave bus
);

    localparam int MAX_CNT = (DIV_COUNT > BLANK_CYCLES) ?
                             DIV_COUNT : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int BLK_T   = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;

    state_t     state;
    dig_idx_t   idx;
    dig_idx_t   nidx;
    logic [23:0] snap;
    logic [23:0] live;
    logic [3:0] digito;
    logic       blank_q;
    logic       fs_q;
    logic       show_en;
    logic       blank_en;
    logic       dwell_done;
    logic       blank_done;
    logic       advance;
    logic       entry;

    assign live     = {bus.hora_bcd, bus.min_bcd, bus.seg_bcd};
    assign show_en  = (state == SHOW);
    assign blank_en = (state == BLANK);

    always_comb begin
        advance = 1'b0;
        case (state)
            SHOW:    advance = dwell_done && (BLANK_CYCLES == 0);
            BLANK:   advance = blank_done;
            default: advance = 1'b0;
        endcase
        // every state change (and show-to-show) restarts both counters
        entry = !bus.enable || (state == IDLE) || advance ||
                (show_en && dwell_done);
        nidx  = next_digit(idx);
    end

    contador_divisor #(
        .WIDTH    (CW),
        .TERMINAL (DIV_COUNT)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clear (entry),
        .en    (show_en),
        .done  (dwell_done)
    );

    contador_divisor #(
        .WIDTH    (CW),
        .TERMINAL (BLK_T)
    ) u_blank (
        .clk   (clk),
        .reset (reset),
        .clear (entry),
        .en    (blank_en),
        .done  (blank_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= DIG_SEG1;
            snap    <= '0;
            digito  <= '0;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (!bus.enable) begin
                state   <= IDLE;
                idx     <= DIG_SEG1;
                blank_q <= 1'b1;
            end else if (state == IDLE || advance) begin
                state   <= SHOW;
                blank_q <= 1'b0;
                // a new frame latches all six digits at once
                if (state == IDLE || nidx == DIG_SEG1) begin
                    idx    <= DIG_SEG1;
                    snap   <= live;
                    digito <= bus.seg_bcd[3:0];
                    fs_q   <= 1'b1;
                end else begin
                    idx    <= nidx;
                    digito <= pick_digit(snap, nidx);
                end
            end else if (show_en && dwell_done) begin
                state   <= BLANK;
                blank_q <= 1'b1;
            end
        end
    end

    assign bus.cont_anodo  = idx;
    assign bus.digito_bcd  = digito;
    assign bus.blank       = blank_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_barrido_display.sv
// Self-checking bench for barrido_display: two instances (with and
// without blanking) checked against a time-based reference model.
module tb_barrido_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_r;
    logic [23:0] din;

    int checks = 0;
    int fails  = 0;

    int          t0, t1;
    logic [23:0] snap0, snap1;
    logic [8:0]  exp0, exp1, msk0, msk1;
    logic [8:0]  obs0, obs1;

    always #5 clk = ~clk;

    barrido_display_if bus0 ();
    barrido_display_if bus1 ();

    assign bus0.enable   = en_r;
    assign bus0.seg_bcd  = din[7:0];
    assign bus0.min_bcd  = din[15:8];
    assign bus0.hora_bcd = din[23:16];
    assign bus1.enable   = en_r;
    assign bus1.seg_bcd  = din[7:0];
    assign bus1.min_bcd  = din[15:8];
    assign bus1.hora_bcd = din[23:16];

    barrido_display #(
        .DIV_COUNT    (4),
        .BLANK_CYCLES (2)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    barrido_display #(
        .DIV_COUNT    (4),
        .BLANK_CYCLES (0)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    assign obs0 = {bus0.cont_anodo, bus0.digito_bcd,
                   bus0.blank, bus0.frame_start};
    assign obs1 = {bus1.cont_anodo, bus1.digito_bcd,
                   bus1.blank, bus1.frame_start};

    // t = cycles since the scan started; everything follows from it
    task automatic model_step(
        input  logic        rst,
        input  logic        en,
        input  logic [23:0] d_in,
        input  int          div,
        input  int          blk,
        inout  int          t,
        inout  logic [23:0] snap,
        output logic [8:0]  e,
        output logic [8:0]  m
    );
        int p, d;
        p = div + blk;
        if (rst) begin
            t    = -1;
            snap = '0;
            e    = {3'd0, 4'd0, 1'b1, 1'b0};
            m    = 9'h1FF;
        end else if (!en) begin
            t = -1;
            e = {3'd0, 4'd0, 1'b1, 1'b0};
            m = 9'b111_0000_11;
        end else begin
            t = t + 1;
            if (t % (6 * p) == 0) snap = d_in;
            d = (t / p) % 6;
            e = {3'(d), snap[4*d +: 4], (t % p) >= div,
                 (t % (6 * p)) == 0};
            m = 9'h1FF;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset, en_r, din, 4, 2, t0, snap0, exp0, msk0);
        model_step(reset, en_r, din, 4, 0, t1, snap1, exp1, msk1);
        #1;
    endtask

    function automatic logic [7:0] rbcd(input int hi_max);
        return {4'($urandom_range(0, hi_max)),
                4'($urandom_range(0, 9))};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en_r  = 1'b0;
        din   = 24'h123459;
        repeat (2) begin
            tick();
            checks++;
            if (obs0 !== exp0) begin
                fails++;
                $display("FAIL reset0 got %h want %h", obs0, exp0);
            end
            checks++;
            if (obs1 !== exp1) begin
                fails++;
                $display("FAIL reset1 got %h want %h", obs1, exp1);
            end
        end
    endtask

    task automatic test_scan();
        int fs_cnt;
        fs_cnt = 0;
        reset  = 1'b0;
        en_r   = 1'b1;
        din    = 24'h123459;
        repeat (72) begin
            tick();
            if (bus0.frame_start) fs_cnt++;
            checks++;
            if ((obs0 & msk0) !== (exp0 & msk0)) begin
                fails++;
                $display("FAIL scan0 t=%0d got %h want %h",
                         t0, obs0, exp0);
            end
            checks++;
            if ((obs1 & msk1) !== (exp1 & msk1)) begin
                fails++;
                $display("FAIL scan1 t=%0d got %h want %h",
                         t1, obs1, exp1);
            end
        end
        checks++;
        if (fs_cnt !== 2) begin
            fails++;
            $display("FAIL scan_frames got %0d want 2", fs_cnt);
        end
    endtask

    task automatic test_snapshot();
        int n;
        n = 0;
        while (!((t0 % 36) >= 6 && (t0 % 36) <= 9) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            fails++;
            $display("FAIL snap_wait got timeout want digit1");
        end
        din[7:0] = 8'h00;
        for (int i = 0; i < 80; i++) begin
            if (i % 7 == 3) din[15:8] = rbcd(5);
            tick();
            checks++;
            if ((obs0 & msk0) !== (exp0 & msk0)) begin
                fails++;
                $display("FAIL snap0 t=%0d got %h want %h",
                         t0, obs0, exp0);
            end
            checks++;
            if ((obs1 & msk1) !== (exp1 & msk1)) begin
                fails++;
                $display("FAIL snap1 t=%0d got %h want %h",
                         t1, obs1, exp1);
            end
        end
    endtask

    task automatic test_enable_drop();
        int n, tgt;
        n   = 0;
        tgt = 18 + int'($urandom_range(0, 5));
        while ((t0 % 36) != tgt && n < 40) begin
            tick();
            n++;
        end
        en_r = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 4)) + 40; i++) begin
            if (i == 3) begin
                en_r = 1'b1;
                din  = {rbcd(2), rbcd(5), rbcd(5)};
            end
            tick();
            checks++;
            if ((obs0 & msk0) !== (exp0 & msk0)) begin
                fails++;
                $display("FAIL endrop0 t=%0d got %h want %h",
                         t0, obs0, exp0);
            end
            checks++;
            if ((obs1 & msk1) !== (exp1 & msk1)) begin
                fails++;
                $display("FAIL endrop1 t=%0d got %h want %h",
                         t1, obs1, exp1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, tgt;
        n   = 0;
        tgt = 28 + int'($urandom_range(0, 1));
        while ((t0 % 36) != tgt && n < 40) begin
            tick();
            n++;
        end
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 1) reset = 1'b0;
            tick();
            checks++;
            if ((obs0 & msk0) !== (exp0 & msk0)) begin
                fails++;
                $display("FAIL rstmid0 t=%0d got %h want %h",
                         t0, obs0, exp0);
            end
            checks++;
            if ((obs1 & msk1) !== (exp1 & msk1)) begin
                fails++;
                $display("FAIL rstmid1 t=%0d got %h want %h",
                         t1, obs1, exp1);
            end
        end
    endtask

    task automatic test_no_blank();
        int wraps;
        logic [2:0] prev;
        wraps = 0;
        prev  = bus1.cont_anodo;
        repeat (60) begin
            tick();
            if (prev == 3'd5 && bus1.cont_anodo == 3'd0) wraps++;
            prev = bus1.cont_anodo;
            checks++;
            if (bus1.blank !== 1'b0 || bus1.cont_anodo > 3'd5) begin
                fails++;
                $display("FAIL noblank got blank=%b idx=%0d want 0/<6",
                         bus1.blank, bus1.cont_anodo);
            end
            checks++;
            if ((obs1 & msk1) !== (exp1 & msk1)) begin
                fails++;
                $display("FAIL noblank1 t=%0d got %h want %h",
                         t1, obs1, exp1);
            end
        end
        checks++;
        if (wraps < 2) begin
            fails++;
            $display("FAIL wrap got %0d want >=2", wraps);
        end
    endtask

    task automatic test_bad_bcd();
        din = {8'hFA, rbcd(5), rbcd(5)};
        repeat (80) begin
            tick();
            checks++;
            if ((obs0 & msk0) !== (exp0 & msk0)) begin
                fails++;
                $display("FAIL badbcd0 t=%0d got %h want %h",
                         t0, obs0, exp0);
            end
            checks++;
            if ((obs1 & msk1) !== (exp1 & msk1)) begin
                fails++;
                $display("FAIL badbcd1 t=%0d got %h want %h",
                         t1, obs1, exp1);
            end
        end
    endtask

    initial begin
        t0    = -1;
        t1    = -1;
        snap0 = '0;
        snap1 = '0;
        test_reset();
        test_scan();
        test_snapshot();
        test_enable_drop();
        test_reset_mid();
        test_no_blank();
        test_bad_bcd();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
